// File: rtl/mario_pkg.sv
// Shared types and defaults for the Mario background-tile VRAM arbiter.
package mario_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAccess,
    StDone
  } state_e;

  typedef enum logic {
    OpRd = 1'b0,
    OpWr = 1'b1
  } op_e;

  localparam logic [3:0]  H_SLOT_DEFAULT  = 4'hF;
  localparam int unsigned ACC_LEN_DEFAULT = 2;

endpackage

// File: rtl/mario_vram_arb.sv
// CPU/video arbiter for the 1KB background VRAM: grants the CPU one slot per 16 phases during
// active display, any tick during blanking, and holds the Z80 on WAITn until the access is done.
module mario_vram_arb
  import mario_pkg::*;
#(
  parameter logic [3:0]  SLOT_PH = H_SLOT_DEFAULT,
  parameter int unsigned ACC_LEN = ACC_LEN_DEFAULT,
  parameter logic [7:0]  TMO_MAX = 8'd200
) (
  input  logic       I_CLK_48M,
  input  logic       I_RST,
  input  logic       I_CEN_24Mp,
  input  logic [9:0] I_H_CNT,
  input  logic       I_CMPBLK,
  input  logic [9:0] I_CPU_AB,
  input  logic [7:0] I_CPU_DB,
  input  logic       I_CPU_RDn,
  input  logic       I_CPU_WRn,
  input  logic [7:0] I_VRAM_DO,
  output logic [9:0] O_VRAM_AB,
  output logic [7:0] O_VRAM_DI,
  output logic       O_VRAM_RDn,
  output logic       O_VRAM_WRn,
  output logic [7:0] O_CPU_DB,
  output logic       O_CPU_WAITn,
  output logic       O_TIMEOUT
);

  localparam logic [2:0] AccLoad = 3'(ACC_LEN - 1);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [9:0] ab_q, ab_d;
  logic [7:0] di_q, di_d;
  logic       rdn_q, rdn_d;
  logic       wrn_q, wrn_d;
  logic       waitn_q, waitn_d;
  logic [7:0] cpu_db_q, cpu_db_d;
  logic       tmo_q, tmo_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [2:0] acnt_q, acnt_d;

  logic slot_open;
  logic req_held;
  logic unused_h_cnt;

  assign unused_h_cnt = ^I_H_CNT[9:4];
  assign slot_open    = ~I_CMPBLK | (I_H_CNT[3:0] == SLOT_PH);
  assign req_held     = (op_q == OpWr) ? ~I_CPU_WRn : ~I_CPU_RDn;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ab_d     = ab_q;
    di_d     = di_q;
    rdn_d    = rdn_q;
    wrn_d    = wrn_q;
    waitn_d  = waitn_q;
    cpu_db_d = cpu_db_q;
    tmo_d    = tmo_q;
    wcnt_d   = wcnt_q;
    acnt_d   = acnt_q;

    case (state_q)
      StIdle: begin
        // Write has priority when both strobes are low; the read is dropped.
        if (!I_CPU_WRn) begin
          op_d    = OpWr;
          ab_d    = I_CPU_AB;
          di_d    = I_CPU_DB;
          waitn_d = 1'b0;
          wcnt_d  = 8'd0;
          state_d = StReq;
        end else if (!I_CPU_RDn) begin
          op_d    = OpRd;
          ab_d    = I_CPU_AB;
          waitn_d = 1'b0;
          wcnt_d  = 8'd0;
          state_d = StReq;
        end
      end

      StReq: begin
        if (!req_held) begin
          waitn_d = 1'b1;
          state_d = StIdle;
        end else if (slot_open) begin
          acnt_d  = AccLoad;
          state_d = StAccess;
          if (op_q == OpWr) begin
            wrn_d = 1'b0;
          end else begin
            rdn_d = 1'b0;
          end
        end else begin
          if (wcnt_q != 8'hFF) begin
            wcnt_d = wcnt_q + 8'd1;
          end
          if (wcnt_d >= TMO_MAX) begin
            tmo_d = 1'b1;
          end
        end
      end

      StAccess: begin
        // CPU strobe is ignored here so a write is never torn.
        if (acnt_q == 3'd0) begin
          rdn_d   = 1'b1;
          wrn_d   = 1'b1;
          waitn_d = 1'b1;
          state_d = StDone;
          if (op_q == OpRd) begin
            cpu_db_d = I_VRAM_DO;
          end
        end else begin
          acnt_d = acnt_q - 3'd1;
        end
      end

      StDone: begin
        if (I_CPU_RDn && I_CPU_WRn) begin
          wcnt_d  = 8'd0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_CLK_48M) begin
    if (I_RST) begin
      state_q  <= StIdle;
      op_q     <= OpRd;
      ab_q     <= 10'd0;
      di_q     <= 8'd0;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      waitn_q  <= 1'b1;
      cpu_db_q <= 8'd0;
      tmo_q    <= 1'b0;
      wcnt_q   <= 8'd0;
      acnt_q   <= 3'd0;
    end else if (I_CEN_24Mp) begin
      state_q  <= state_d;
      op_q     <= op_d;
      ab_q     <= ab_d;
      di_q     <= di_d;
      rdn_q    <= rdn_d;
      wrn_q    <= wrn_d;
      waitn_q  <= waitn_d;
      cpu_db_q <= cpu_db_d;
      tmo_q    <= tmo_d;
      wcnt_q   <= wcnt_d;
      acnt_q   <= acnt_d;
    end
  end

  assign O_VRAM_AB   = ab_q;
  assign O_VRAM_DI   = di_q;
  assign O_VRAM_RDn  = rdn_q;
  assign O_VRAM_WRn  = wrn_q;
  assign O_CPU_DB    = cpu_db_q;
  assign O_CPU_WAITn = waitn_q;
  assign O_TIMEOUT   = tmo_q;

endmodule

// File: tb/tb_mario_vram_arb.sv
// Scoreboard bench for mario_vram_arb: each CPU cycle queues its expected VRAM activity, and a
// monitor measures every WAITn-low window and compares it when WAITn returns high.
module tb_mario_vram_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic [9:0] h_cnt = 10'd0;
  logic       cmpblk = 1'b0;
  logic [9:0] cpu_ab = 10'd0;
  logic [7:0] cpu_db = 8'd0;
  logic       cpu_rdn = 1'b1;
  logic       cpu_wrn = 1'b1;
  logic [7:0] vram_do = 8'd0;
  logic [9:0] vram_ab;
  logic [7:0] vram_di;
  logic       vram_rdn;
  logic       vram_wrn;
  logic [7:0] cpu_q;
  logic       waitn;
  logic       tmo;

  logic h_run  = 1'b0;
  logic mon_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    int         wait_len;
    int         grant_at;
    int         rd_len;
    int         wr_len;
    logic [9:0] ab;
    logic [7:0] di;
    logic       chk_di;
    logic [7:0] cpu_db;
  } exp_t;

  exp_t exp_q[$];

  mario_vram_arb dut (
    .I_CLK_48M  (clk),
    .I_RST      (rst),
    .I_CEN_24Mp (cen),
    .I_H_CNT    (h_cnt),
    .I_CMPBLK   (cmpblk),
    .I_CPU_AB   (cpu_ab),
    .I_CPU_DB   (cpu_db),
    .I_CPU_RDn  (cpu_rdn),
    .I_CPU_WRn  (cpu_wrn),
    .I_VRAM_DO  (vram_do),
    .O_VRAM_AB  (vram_ab),
    .O_VRAM_DI  (vram_di),
    .O_VRAM_RDn (vram_rdn),
    .O_VRAM_WRn (vram_wrn),
    .O_CPU_DB   (cpu_q),
    .O_CPU_WAITn(waitn),
    .O_TIMEOUT  (tmo)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen = ~cen;

  task automatic wait_tick();
    do @(posedge clk); while (cen !== 1'b1);
  endtask

  // Advance one enabled tick; the video counter moves after the DUT has sampled it.
  task automatic tick();
    wait_tick();
    #1;
    if (h_run) h_cnt = h_cnt + 10'd1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int wl, input int ga, input int rl, input int wrl, input logic [9:0] a,
                      input logic [7:0] d, input logic cd, input logic [7:0] cq);
    exp_t e;
    e.wait_len = wl; e.grant_at = ga; e.rd_len = rl; e.wr_len = wrl;
    e.ab = a; e.di = d; e.chk_di = cd; e.cpu_db = cq;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    logic       prev_w = 1'b1;
    logic       active = 1'b0;
    logic       stable = 1'b1;
    int         cnt = 0, rd_len = 0, wr_len = 0, grant = 0;
    logic [9:0] ab_s = 10'd0;
    logic [7:0] di_s = 8'd0;
    exp_t       e;
    forever begin
      wait_tick();
      #2;
      if (mon_en) begin
        if (!active) begin
          if (prev_w && !waitn) begin
            active = 1'b1; cnt = 0; rd_len = 0; wr_len = 0; grant = 0; stable = 1'b1;
          end else begin
            chk("idle_strobe", int'({vram_rdn, vram_wrn}), 3);
          end
        end else begin
          cnt++;
          if (!vram_rdn) rd_len++;
          if (!vram_wrn) wr_len++;
          if (!vram_rdn || !vram_wrn) begin
            if (grant == 0) begin
              grant = cnt; ab_s = vram_ab; di_s = vram_di;
            end else if (vram_ab != ab_s || vram_di != di_s) begin
              stable = 1'b0;
            end
          end
          if (waitn) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_completion", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("wait_len", cnt, e.wait_len);
              chk("grant_at", grant, e.grant_at);
              chk("rd_len", rd_len, e.rd_len);
              chk("wr_len", wr_len, e.wr_len);
              chk("cpu_db", int'(cpu_q), int'(e.cpu_db));
              if (e.grant_at != 0) begin
                chk("vram_ab", int'(ab_s), int'(e.ab));
                chk("addr_data_stable", int'(stable), 1);
                if (e.chk_di) chk("vram_di", int'(di_s), int'(e.di));
              end
            end
          end
        end
        prev_w = waitn;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    repeat (3) tick();
    chk("rst_vram_rdn", int'(vram_rdn), 1);
    chk("rst_vram_wrn", int'(vram_wrn), 1);
    chk("rst_waitn", int'(waitn), 1);
    chk("rst_vram_ab", int'(vram_ab), 0);
    chk("rst_vram_di", int'(vram_di), 0);
    chk("rst_cpu_db", int'(cpu_q), 0);
    chk("rst_timeout", int'(tmo), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Blanking write, then hold WRn low in DONE to show no second access.
    cmpblk = 1'b0; cpu_ab = 10'h155; cpu_db = 8'hA5;
    push(3, 1, 0, 2, 10'h155, 8'hA5, 1'b1, 8'h00);
    cpu_wrn = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold_waitn", int'(waitn), 1);
      chk("done_hold_wrn", int'(vram_wrn), 1);
    end
    cpu_wrn = 1'b1;
    repeat (2) tick();

    // Active-display read issued at phase 3; grant only at phase F.
    cmpblk = 1'b1; h_cnt = 10'd3; h_run = 1'b1; vram_do = 8'h3C; cpu_ab = 10'h0AB;
    push(14, 12, 2, 0, 10'h0AB, 8'h00, 1'b0, 8'h3C);
    cpu_rdn = 1'b0;
    repeat (15) tick();
    cpu_rdn = 1'b1;
    repeat (2) tick();
    h_run = 1'b0;

    // Both strobes low: write wins.
    cmpblk = 1'b0; cpu_ab = 10'h2AA; cpu_db = 8'h5A;
    push(3, 1, 0, 2, 10'h2AA, 8'h5A, 1'b1, 8'h3C);
    cpu_rdn = 1'b0; cpu_wrn = 1'b0;
    repeat (4) tick();
    cpu_rdn = 1'b1; cpu_wrn = 1'b1;
    repeat (2) tick();

    // Abort in REQ before the slot.
    cmpblk = 1'b1; h_cnt = 10'd5; h_run = 1'b1; cpu_ab = 10'h111;
    push(1, 0, 0, 0, 10'h000, 8'h00, 1'b0, 8'h3C);
    cpu_rdn = 1'b0;
    tick();
    cpu_rdn = 1'b1;
    tick();
    chk("abort_waitn", int'(waitn), 1);
    repeat (2) tick();
    h_run = 1'b0;

    // Reset in the middle of a write access.
    cmpblk = 1'b0; cpu_ab = 10'h0F0; cpu_db = 8'hC3;
    push(2, 1, 0, 1, 10'h0F0, 8'hC3, 1'b1, 8'h00);
    cpu_wrn = 1'b0;
    repeat (2) tick();
    chk("pre_rst_strobe", int'(vram_wrn), 0);
    rst = 1'b1;
    tick();
    chk("midrst_wrn", int'(vram_wrn), 1);
    chk("midrst_rdn", int'(vram_rdn), 1);
    chk("midrst_waitn", int'(waitn), 1);
    chk("midrst_cpu_db", int'(cpu_q), 0);
    chk("midrst_vram_ab", int'(vram_ab), 0);
    rst = 1'b0; cpu_wrn = 1'b1;
    repeat (2) tick();

    // Timeout with the slot never reached.
    cmpblk = 1'b1; h_run = 1'b0; h_cnt = 10'd0; cpu_ab = 10'h3FF;
    push(201, 0, 0, 0, 10'h000, 8'h00, 1'b0, 8'h00);
    cpu_rdn = 1'b0;
    repeat (200) tick();
    chk("timeout_before", int'(tmo), 0);
    tick();
    chk("timeout_reached", int'(tmo), 1);
    cpu_rdn = 1'b1;
    repeat (2) tick();
    chk("timeout_sticky", int'(tmo), 1);
    chk("timeout_waitn", int'(waitn), 1);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mario_vram_arb.md
Name: mario_vram_arb

Overview:
- Arbitrates the 1KB background-tile VRAM between Z80 CPU reads/writes and the video tile fetch.
- Sits between the CPU bus decode and the VRAM block. It drives the VRAM address, strobes and data, and holds the CPU with WAITn until a legal VRAM slot has been granted and the access has finished.
- During active display, the CPU gets only one slot per 16 half-pixel phases. During blanking the VRAM is fully free.

Parameters:
- SLOT_PH, 4'hF: I_H_CNT[3:0] value that opens the CPU slot during active display.
- ACC_LEN, 2: number of 24M clock-enable ticks a granted access occupies (1..7).
- TMO_MAX, 8'd200: clock-enable ticks of waiting before the timeout flag is raised.

Ports:
- I_CLK_48M  in  1  system clock.
- I_RST  in  1  synchronous active-high reset.
- I_CEN_24Mp  in  1  clock enable; every state or register update is qualified by it.
- I_H_CNT  in  10  horizontal counter.
- I_CMPBLK  in  1  1 = active display (video owns VRAM except in the slot).
- I_CPU_AB  in  10  CPU address.
- I_CPU_DB  in  8  CPU write data.
- I_CPU_RDn  in  1  CPU VRAM read strobe, active low.
- I_CPU_WRn  in  1  CPU VRAM write strobe, active low.
- I_VRAM_DO  in  8  VRAM read data.
- O_VRAM_AB  out  10  address to VRAM (CPU side).
- O_VRAM_DI  out  8  write data to VRAM.
- O_VRAM_RDn  out  1  VRAM read strobe.
- O_VRAM_WRn  out  1  VRAM write strobe.
- O_CPU_DB  out  8  latched read data.
- O_CPU_WAITn  out  1  CPU wait, active low.
- O_TIMEOUT  out  1  sticky wait-timeout flag.

Behaviour:
- All transitions happen on I_CLK_48M edges where I_CEN_24Mp=1. Between enables, all state holds.
- Reset (I_RST=1, any state):
  - State IDLE.
  - O_VRAM_RDn=1, O_VRAM_WRn=1, O_CPU_WAITn=1.
  - O_VRAM_AB=0, O_VRAM_DI=0, O_CPU_DB=0, O_TIMEOUT=0, wait counter=0.
  - A reset asserted mid-access abandons the access immediately; no strobe remains asserted.
- slot_open = ~I_CMPBLK | (I_H_CNT[3:0]==SLOT_PH), evaluated on the current tick.
- IDLE:
  - If WRn=0, latch AB/DB, op=WR. Else if RDn=0, latch AB, op=RD.
  - With both strobes low, the write wins; the read is dropped.
  - A latched request drops WAITn to 0 on the same tick, then goes to REQ.
- REQ:
  - Strobe released → IDLE, WAITn=1, no VRAM access (abort).
  - Else if slot_open → ACCESS: assert RDn or WRn, load access counter = ACC_LEN-1.
  - Else stay in REQ, incrementing the saturating 8-bit wait counter. Reaching TMO_MAX sets O_TIMEOUT.
- ACCESS:
  - The strobe stays asserted for exactly ACC_LEN ticks. Address and data are stable for the whole access.
  - Access counter = 0 → deassert the strobe. For RD, capture I_VRAM_DO into O_CPU_DB on that same tick. Go to DONE.
  - CPU strobe release during ACCESS is ignored; the access always completes, so writes are never torn.
- DONE:
  - WAITn=1. O_CPU_DB holds its value.
  - Stay until both CPU strobes are high, then IDLE with wait counter cleared.
  - This prevents one CPU cycle being serviced twice.
- Slot opening while already in ACCESS has no effect. A slot that coincides with the request tick is not used; the earliest grant is the tick after IDLE.
- During blanking, a request is granted on the next tick, giving a latency of 2 + ACC_LEN ticks to WAITn=1.
- O_TIMEOUT is cleared only by reset.

Decomposition:
- Shared package mario_pkg holds:
  - the state enum (IDLE, REQ, ACCESS, DONE);
  - the op encoding (RD=0, WR=1);
  - constants H_SLOT_DEFAULT and ACC_LEN_DEFAULT.
- No sub-module; a single FSM plus counters.

Test Plan:
- Blanking write: I_CMPBLK=0, WRn=0, AB=10'h155, DB=8'hA5 → WAITn low 1 tick later, O_VRAM_WRn low exactly 2 ticks with AB=155/DI=A5, WAITn high after 4 ticks.
- Active read: I_CMPBLK=1, RDn=0 at H_CNT[3:0]=3, VRAM returns 8'h3C → RDn asserted only from phase F, O_CPU_DB=3C, WAITn released 2 ticks after the grant.
- Both strobes low in IDLE → only O_VRAM_WRn pulses; O_VRAM_RDn stays 1.
- Abort: RDn released in REQ before the slot → no VRAM strobe, WAITn returns high next tick.
- Reset mid-ACCESS → next enabled tick has all strobes high, WAITn=1, O_CPU_DB=0.
- Timeout: I_CMPBLK=1 with the slot never reached (H_CNT frozen at 0) and RDn held low → O_TIMEOUT=1 after 200 ticks and remains 1 after RDn is released.
